// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types for the DE0-Nano CPU clock/reset controller.
// Clock FSM states and the edge counter width.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    PAUSE,
    STEP_HI,
    STEP_LO
  } clk_state_t;

  localparam int EDGE_W = 16;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton synchronizer and debouncer for active-low board keys.
// Emits a one-cycle press pulse on each accepted release-to-press change.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      press <= 1'b0;
      // any sample that agrees with the held level restarts the run
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Slow CPU clock with glitch-free pause and single-step, plus
// a CPU reset stretched over a number of CPU clock edges.
module cpu_clock_ctrl
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int DIV_BITS   = 26,
  parameter int DEB_CYCLES = 500000,
  parameter int STEP_HALF  = 16,
  parameter int RST_EDGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              step_key,
  input  logic              cpu_reset_req,
  output logic              cpu_clock,
  output logic              cpu_reset,
  output logic              paused,
  output logic [EDGE_W-1:0] edge_count
);

  localparam int PW = $clog2(STEP_HALF + 1);
  localparam int RW = $clog2(RST_EDGES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(STEP_HALF - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_EDGES);
  localparam logic [RW-1:0] RST_ONE = RW'(1);

  logic [1:0] pause_sync;
  logic [1:0] req_sync;
  logic       pause_s;
  logic       req_s;
  logic       step_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pause_sync <= 2'b00;
      req_sync   <= 2'b00;
    end else begin
      pause_sync <= {pause_sync[0], pause};
      req_sync   <= {req_sync[0], cpu_reset_req};
    end
  end

  assign pause_s = pause_sync[1];
  assign req_s   = req_sync[1];

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_key (
    .clk    (clk),
    .reset  (reset),
    .key_raw(step_key),
    .press  (step_req)
  );

  clk_state_t          state;
  logic [DIV_BITS-1:0] divider;
  logic [DIV_BITS-1:0] div_inc;
  logic [PW-1:0]       phase;

  assign div_inc = divider + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      divider    <= '0;
      phase      <= '0;
      cpu_clock  <= 1'b0;
      paused     <= 1'b0;
      edge_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          // in RUN cpu_clock mirrors the divider MSB
          if (pause_s && !divider[DIV_BITS-1]) begin
            state  <= PAUSE;
            paused <= 1'b1;
          end else begin
            divider   <= div_inc;
            cpu_clock <= div_inc[DIV_BITS-1];
            if (!cpu_clock && div_inc[DIV_BITS-1])
              edge_count <= edge_count + 1'b1;
            if (pause_s && div_inc == '0) begin
              state  <= PAUSE;
              paused <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (step_req) begin
            state      <= STEP_HI;
            phase      <= '0;
            cpu_clock  <= 1'b1;
            edge_count <= edge_count + 1'b1;
          end else if (!pause_s) begin
            state  <= RUN;
            paused <= 1'b0;
          end
        end
        STEP_HI: begin
          if (phase == PH_LAST) begin
            state     <= STEP_LO;
            phase     <= '0;
            cpu_clock <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        STEP_LO: begin
          if (phase == PH_LAST) begin
            state <= PAUSE;
            phase <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  logic          clk_d;
  logic [RW-1:0] hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_reset <= 1'b1;
      hold      <= RST_LOAD;
      clk_d     <= 1'b0;
    end else begin
      clk_d <= cpu_clock;
      if (req_s) begin
        cpu_reset <= 1'b1;
        hold      <= RST_LOAD;
      end else if (cpu_reset && cpu_clock && !clk_d) begin
        // drop one cycle after the last counted rising edge
        if (hold == RST_ONE)
          cpu_reset <= 1'b0;
        hold <= hold - 1'b1;
      end
    end
  end

endmodule
